// File: rtl/fft_peak_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_peak_detect                                              |
// | Description : Streams approximate per-bin magnitudes of an FFT output      |
// |               frame and reports the strongest positive-frequency bin.      |
// |               Optional magnitude readback RAM enabled by FFT_PEAK_RAM_EN.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_peak_detect #(
  parameter int WIDTH   = 16,
  parameter int M       = 9,
  parameter int POINTS  = 2**M,
  parameter int MIN_BIN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               done,
  input  logic [2*WIDTH-1:0] wd,
  output logic [WIDTH:0]     mag,
  output logic [M-1:0]       mag_bin,
  output logic               mag_valid,
  output logic [M-1:0]       peak_bin,
  output logic [WIDTH:0]     peak_mag,
  output logic               peak_valid,
  output logic               frame_err,
`ifdef FFT_PEAK_RAM_EN
  output logic               busy,
  input  logic [M-2:0]       rdbk_adr,
  output logic [WIDTH:0]     rdbk_data
`else
  output logic               busy
`endif
);

  localparam logic [M-1:0]     LAST_BIN  = M'(POINTS - 1);
  localparam logic [M-1:0]     MIN_BIN_L = M'(MIN_BIN);
  localparam logic [M-1:0]     HALF_BIN  = M'(POINTS / 2);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS  = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    FLUSH    = 3'd2,
    REPORT   = 3'd3,
    WAIT_LOW = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [M-1:0]     cnt;
  logic             capture;
  logic [M-1:0]     cap_bin;
  logic             abort;
  logic             report;
  logic             frame_start;

  logic [WIDTH-1:0] s1_a, s1_b;
  logic [M-1:0]     s1_bin;
  logic             s1_valid;

  logic [WIDTH-1:0] w_max, w_min;
  logic [WIDTH:0]   w_mag;
  logic             in_range;

  logic [WIDTH:0]   max_mag;
  logic [M-1:0]     max_bin;
  logic             have_max;

  // Two's complement absolute value; the most negative code saturates so the
  // result always fits in WIDTH-1 magnitude bits.
  function automatic logic [WIDTH-1:0] sat_abs(input logic [WIDTH-1:0] x);
    if (x == MOST_NEG)
      sat_abs = MOST_POS;
    else if (x[WIDTH-1])
      sat_abs = ~x + WIDTH'(1);
    else
      sat_abs = x;
  endfunction

  // Frame-control state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Frame-control next state and per-cycle capture/abort/report strobes.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    cap_bin   = cnt;
    abort     = 1'b0;
    report    = 1'b0;
    case (state)
      IDLE: begin
        if (done) begin
          capture   = 1'b1;
          cap_bin   = '0;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (done) begin
          capture = 1'b1;
          if (cnt == LAST_BIN) state_nxt = FLUSH;
        end else begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      // Once stage 1 is empty the last bin has been folded into the search.
      FLUSH: begin
        if (!s1_valid) state_nxt = REPORT;
      end
      REPORT: begin
        report    = 1'b1;
        state_nxt = WAIT_LOW;
      end
      // A done held high past the frame end must not start a new frame.
      WAIT_LOW: begin
        if (!done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign frame_start = capture && (state == IDLE);

  // Bin counter: index of the next bin to capture.
  always_ff @(posedge clk) begin
    if (reset || abort)
      cnt <= '0;
    else if (capture)
      cnt <= (state_nxt == FLUSH) ? '0 : cap_bin + M'(1);
  end

  // Stage 1: absolute values of the real and imaginary parts.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_a     <= '0;
      s1_b     <= '0;
      s1_bin   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= capture;
      if (capture) begin
        s1_a   <= sat_abs(wd[2*WIDTH-1:WIDTH]);
        s1_b   <= sat_abs(wd[WIDTH-1:0]);
        s1_bin <= cap_bin;
      end
    end
  end

  // Alpha-max plus beta-min estimate with alpha=1, beta=1/2.
  assign w_max    = (s1_a >= s1_b) ? s1_a : s1_b;
  assign w_min    = (s1_a >= s1_b) ? s1_b : s1_a;
  assign w_mag    = {1'b0, w_max} + {1'b0, (w_min >> 1)};
  assign in_range = s1_valid && (s1_bin >= MIN_BIN_L) && (s1_bin < HALF_BIN);

  // Stage 2: registered magnitude stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      mag       <= '0;
      mag_bin   <= '0;
      mag_valid <= 1'b0;
    end else begin
      mag_valid <= s1_valid;
      if (s1_valid) begin
        mag     <= w_mag;
        mag_bin <= s1_bin;
      end
    end
  end

  // Running maximum over the positive-frequency range; strict compare keeps
  // the lowest index on ties.
  always_ff @(posedge clk) begin
    if (reset || abort || frame_start) begin
      max_mag  <= '0;
      max_bin  <= MIN_BIN_L;
      have_max <= 1'b0;
    end else if (in_range && (!have_max || (w_mag > max_mag))) begin
      max_mag  <= w_mag;
      max_bin  <= s1_bin;
      have_max <= 1'b1;
    end
  end

  // Report registers and status pulses; peak values hold across aborts.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_bin   <= '0;
      peak_mag   <= '0;
      peak_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      peak_valid <= report;
      frame_err  <= abort;
      if (report) begin
        peak_bin <= max_bin;
        peak_mag <= max_mag;
      end
    end
  end

  // Busy spans first captured bin through the report or abort pulse.
  always_ff @(posedge clk) begin
    if (reset || report || abort) busy <= 1'b0;
    else if (frame_start)         busy <= 1'b1;
  end

`ifdef FFT_PEAK_RAM_EN
  logic [WIDTH:0] mag_ram [POINTS/2];

  // Magnitude store for the lower half and registered read-before-write port.
  always_ff @(posedge clk) begin
    if (s1_valid && (s1_bin < HALF_BIN))
      mag_ram[s1_bin[M-2:0]] <= w_mag;
    rdbk_data <= mag_ram[rdbk_adr];
  end
`endif

endmodule
`default_nettype wire
